// File: rtl/imm_gen_stage.sv
// RV32I immediate generator (I/S/B/U/J, optional CSR zimm under IMM_GEN_ZIMM_EN) behind a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid; one result per cycle when streaming.
// Backpressure: in_ready drops only when both entries are full; it comes from registered count, not from out_ready.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    localparam logic [2:0] SEL_I = 3'd0;
    localparam logic [2:0] SEL_S = 3'd1;
    localparam logic [2:0] SEL_B = 3'd2;
    localparam logic [2:0] SEL_U = 3'd3;
    localparam logic [2:0] SEL_J = 3'd4;
    localparam logic [2:0] SEL_Z = 3'd5;

    entry_t      dec;
    entry_t      head;
    entry_t      tail;
    logic [1:0]  count;
    logic [31:0] raw;
    logic        sgn;
    logic        push;
    logic        pop;

    assign sgn = in_instr[31];

    // Every format is first built as a 32-bit signed value, then widened once to XLEN.
    always_comb begin
        raw     = '0;
        dec     = '0;
        dec.tag = in_tag;
        case (in_sel)
            SEL_I: raw = {{20{sgn}}, in_instr[31:20]};
            SEL_S: raw = {{20{sgn}}, in_instr[31:25], in_instr[11:7]};
            SEL_B: raw = {{19{sgn}}, sgn, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            SEL_U: raw = {in_instr[31:12], 12'b0};
            SEL_J: raw = {{11{sgn}}, sgn, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            default: raw = '0;
        endcase
        case (in_sel)
            SEL_I, SEL_S, SEL_B, SEL_U, SEL_J: dec.imm = XLEN'($signed(raw));
`ifdef IMM_GEN_ZIMM_EN
            SEL_Z: dec.imm = XLEN'(in_instr[19:15]);
`endif
            default: dec.err = 1'b1;
        endcase
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // head always drives the outputs; vacated slots are zeroed so nothing stale is ever shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= dec;
                    else               tail <= dec;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    tail  <= '0;
                    count <= count - 2'd1;
                end
                // Simultaneous push/pop only happens at count 1: the new entry replaces the head.
                2'b11: head <= dec;
                default: ;
            endcase
        end
    end

    assign out_imm = head.imm;
    assign out_tag = head.tag;
    assign out_err = head.err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed and random stimulus for imm_gen_stage against an arithmetic reference model and FIFO scoreboard.
module tb_imm_gen_stage;
    localparam int XLEN  = 32;
    localparam int TAG_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   npop   = 0;

    imm_gen_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Immediate value from the format definitions using integer weights of each field.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [2:0] sl, input logic [31:0] tg);
        exp_t e;
        int   i;
        int   v;
        i = int'(ins);
        v = 0;
        e.err = 1'b0;
        case (sl)
            3'd0: v = i >>> 20;
            3'd1: v = (i >>> 25) * 32 + int'((ins >> 7) & 32'h1F);
            3'd2: v = (i >>> 31) * 4096 + int'((ins >> 7) & 32'h1) * 2048
                      + int'((ins >> 25) & 32'h3F) * 32 + int'((ins >> 8) & 32'hF) * 2;
            3'd3: v = int'(ins & 32'hFFFFF000);
            3'd4: v = (i >>> 31) * 1048576 + int'((ins >> 12) & 32'hFF) * 4096
                      + int'((ins >> 20) & 32'h1) * 2048 + int'((ins >> 21) & 32'h3FF) * 2;
`ifdef IMM_GEN_ZIMM_EN
            3'd5: v = int'((ins >> 15) & 32'h1F);
`endif
            default: e.err = 1'b1;
        endcase
        e.imm = 32'(v);
        e.tag = tg;
        return e;
    endfunction

    // One cycle, starting and ending at a falling edge. use_const selects a hand-written expectation.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [2:0] sl,
                        input logic [31:0] tg, input logic ordy,
                        input logic use_const, input logic [31:0] cimm, input logic cerr);
        exp_t e;
        bit   acc;
        bit   pp;
        in_valid  = iv;
        in_instr  = ins;
        in_sel    = sl;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() != 2));
        if (q.size() != 0) begin
            chk("out_imm", 64'(out_imm), 64'(q[0].imm));
            chk("out_tag", 64'(out_tag), 64'(q[0].tag));
            chk("out_err", 64'(out_err), 64'(q[0].err));
        end
        acc = iv && (q.size() != 2);
        pp  = ordy && (q.size() != 0);
        if (out_valid && ordy) npop++;
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (acc) begin
            if (use_const) begin
                e.imm = cimm;
                e.tag = tg;
                e.err = cerr;
            end else begin
                e = ref_model(ins, sl, tg);
            end
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic mstep(input logic iv, input logic [31:0] ins, input logic [2:0] sl,
                         input logic [31:0] tg, input logic ordy);
        step(iv, ins, sl, tg, ordy, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] z_imm;
        logic        z_err;
`ifdef IMM_GEN_ZIMM_EN
        z_imm = 32'h1F;
        z_err = 1'b0;
`else
        z_imm = 32'h0;
        z_err = 1'b1;
`endif
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_sel = '0; in_tag = '0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_imm", 64'(out_imm), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_out_err", 64'(out_err), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Known encodings for each format
        step(1'b1, 32'hFFF00093, 3'd0, 32'h100, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
        step(1'b1, 32'hFE20AE23, 3'd1, 32'h104, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0);
        step(1'b1, 32'hFE000CE3, 3'd2, 32'h108, 1'b1, 1'b1, 32'hFFFFFFF8, 1'b0);
        step(1'b1, 32'h123450B7, 3'd3, 32'h10C, 1'b1, 1'b1, 32'h12345000, 1'b0);
        step(1'b1, 32'h001000EF, 3'd4, 32'h110, 1'b1, 1'b1, 32'h00000800, 1'b0);
        step(1'b1, 32'hFFF00093, 3'd6, 32'h114, 1'b1, 1'b1, 32'h0, 1'b1);
        step(1'b1, 32'hFFFFFFFF, 3'd7, 32'h118, 1'b1, 1'b1, 32'h0, 1'b1);
        step(1'b1, 32'h000FD073, 3'd5, 32'h11C, 1'b1, 1'b1, z_imm, z_err);
        mstep(1'b0, 32'h0, 3'd0, 32'h0, 1'b1);
        mstep(1'b0, 32'h0, 3'd0, 32'h0, 1'b1);

        // Backpressure: three offers with downstream stalled, then drain
        mstep(1'b1, 32'h80000013, 3'd0, 32'hA1, 1'b0);
        mstep(1'b1, 32'h7FF00023, 3'd1, 32'hA2, 1'b0);
        mstep(1'b1, 32'h800000E3, 3'd2, 32'hA3, 1'b0);
        mstep(1'b1, 32'h800000E3, 3'd2, 32'hA3, 1'b0);
        mstep(1'b0, 32'h0, 3'd0, 32'h0, 1'b1);
        mstep(1'b1, 32'h800000E3, 3'd2, 32'hA3, 1'b1);
        mstep(1'b0, 32'h0, 3'd0, 32'h0, 1'b1);
        mstep(1'b0, 32'h0, 3'd0, 32'h0, 1'b1);
        chk("bp_drained", 64'(q.size()), 64'(0));

        // Streaming: sixteen back-to-back transfers
        npop = 0;
        for (int k = 0; k < 16; k++) begin
            mstep(1'b1, $urandom, 3'($urandom_range(0, 4)), 32'(k), 1'b1);
            if (k > 0) chk("stream_count", 64'(q.size()), 64'(1));
        end
        mstep(1'b0, 32'h0, 3'd0, 32'h0, 1'b1);
        chk("stream_pops", 64'(npop), 64'(16));

        // Reset while both entries are full
        mstep(1'b1, 32'hDEADBEEF, 3'd0, 32'hB1, 1'b0);
        mstep(1'b1, 32'hCAFEF00D, 3'd4, 32'hB2, 1'b0);
        chk("pre_reset_full", 64'(in_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_out_imm", 64'(out_imm), 64'(0));
        chk("mid_rst_out_tag", 64'(out_tag), 64'(0));
        chk("mid_rst_out_err", 64'(out_err), 64'(0));
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mstep(1'b0, 32'h0, 3'd0, 32'h0, 1'b1);
        mstep(1'b0, 32'h0, 3'd0, 32'h0, 1'b0);

        // Random traffic with random stalls and all selector values
        for (int k = 0; k < 600; k++) begin
            mstep(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 2) != 0));
        end
        for (int k = 0; k < 3; k++) mstep(1'b0, 32'h0, 3'd0, 32'h0, 1'b1);
        chk("final_empty", 64'(out_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
